// File: rtl/fma_issue_arb_if.sv
// Request/issue/response bundle between the sine/cosine requesters, the
// FMA issue arbiter and the shared FMA pipeline.
interface fma_issue_arb_if #(
    parameter int PAYLOAD_W = 199
);
    logic [1:0]           i_req_valid;
    logic [PAYLOAD_W-1:0] i_req_data0;
    logic [PAYLOAD_W-1:0] i_req_data1;
    logic [1:0]           o_req_ready;
    logic                 o_fma_valid;
    logic [PAYLOAD_W-1:0] o_fma_data;
    logic                 i_fma_valid;
    logic [1:0]           o_rsp_valid;

    modport slave (
        input  i_req_valid, i_req_data0, i_req_data1, i_fma_valid,
        output o_req_ready, o_fma_valid, o_fma_data, o_rsp_valid
    );

    modport master (
        output i_req_valid, i_req_data0, i_req_data1, i_fma_valid,
        input  o_req_ready, o_fma_valid, o_fma_data, o_rsp_valid
    );
endinterface

// File: rtl/fma_issue_arb.sv
// Two-requester issue arbiter and result router for the shared FMA pipeline.
// Define FMA_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module fma_issue_arb #(
    parameter int PAYLOAD_W = 199,
    parameter int LAT       = 2,
    parameter int MAX_OUTST = 2,
    localparam int CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    fma_issue_arb_if.slave   bus,
    output logic [CNT_W-1:0] o_outst0,
    output logic [CNT_W-1:0] o_outst1,
    output logic             o_err_orphan
);

    logic [1:0]       elig;
    logic [1:0]       grant;
    logic [1:0]       rsp;
    logic [CNT_W-1:0] outst_q [2];
    logic [CNT_W-1:0] outst_d [2];
    logic [LAT-1:0]   tag_vld_q, tag_vld_d;
    logic [LAT-1:0]   tag_id_q, tag_id_d;
    logic             err_q, err_d;
    logic             tail_vld;
`ifndef FMA_ARB_FIXED_PRIO_EN
    logic             rr_q, rr_d;
`endif

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            elig[k] = bus.i_req_valid[k] && (outst_q[k] < CNT_W'(MAX_OUTST));
        end
    end

    always_comb begin
        grant = 2'b00;
`ifdef FMA_ARB_FIXED_PRIO_EN
        if (elig[0]) begin
            grant = 2'b01;
        end else if (elig[1]) begin
            grant = 2'b10;
        end
`else
        if (&elig) begin
            grant = rr_q ? 2'b10 : 2'b01;
        end else begin
            grant = elig;
        end
`endif
        if (i_rst) begin
            grant = 2'b00;
        end
    end

`ifndef FMA_ARB_FIXED_PRIO_EN
    // Pointer moves to the requester that just lost; held when nothing issues.
    always_comb begin
        rr_d = rr_q;
        if (|grant) begin
            rr_d = grant[0];
        end
    end
`endif

    assign bus.o_req_ready = grant;
    assign bus.o_fma_valid = |grant;
    assign bus.o_fma_data  = grant[1] ? bus.i_req_data1 :
                             grant[0] ? bus.i_req_data0 : '0;

    // Tag chain free-runs in lockstep with the FMA valid chain.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = |grant;
        tag_id_d[0]  = grant[1];
        for (int s = 1; s < LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
    end

    assign tail_vld = tag_vld_q[LAT-1];

    always_comb begin
        rsp = 2'b00;
        if (tail_vld && bus.i_fma_valid && !i_rst) begin
            rsp = tag_id_q[LAT-1] ? 2'b10 : 2'b01;
        end
    end

    assign bus.o_rsp_valid = rsp;
    assign err_d           = err_q | (tail_vld ^ bus.i_fma_valid);

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            outst_d[k] = outst_q[k];
            case ({grant[k], rsp[k]})
                2'b10:   outst_d[k] = outst_q[k] + CNT_W'(1);
                2'b01:   outst_d[k] = outst_q[k] - CNT_W'(1);
                default: outst_d[k] = outst_q[k];
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            outst_q[0] <= '0;
            outst_q[1] <= '0;
            err_q      <= 1'b0;
`ifndef FMA_ARB_FIXED_PRIO_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            outst_q[0] <= outst_d[0];
            outst_q[1] <= outst_d[1];
            err_q      <= err_d;
`ifndef FMA_ARB_FIXED_PRIO_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign o_outst0     = outst_q[0];
    assign o_outst1     = outst_q[1];
    assign o_err_orphan = err_q;

endmodule

// File: tb/tb_fma_issue_arb.sv
// Scoreboard bench for fma_issue_arb: directed issue patterns, FMA latency model,
// orphan detection and reset discard.
module tb_fma_issue_arb;
    localparam int PW   = 199;
    localparam int LAT  = 2;
    localparam int MAXO = 2;
    localparam int CW   = $clog2(MAXO + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           inject = 1'b0;
    logic [LAT-1:0] fma_pipe;
    logic [CW-1:0]  outst0, outst1;
    logic           err_orphan;

    int n_cmp = 0;
    int n_err = 0;

    int          exp_iss_id[$];
    logic [PW-1:0] exp_iss_data[$];
    int          exp_rsp_id[$];

`ifdef FMA_ARB_FIXED_PRIO_EN
    int seq_b[6] = '{0, 0, 1, 0, 0, 1};
`else
    int seq_b[6] = '{0, 1, 0, 1, 0, 1};
`endif
    int rdy_c[6] = '{1, 1, 0, 1, 1, 0};
    int out_c[6] = '{0, 1, 2, 1, 1, 2};

    fma_issue_arb_if #(.PAYLOAD_W(PW)) bus();

    fma_issue_arb #(.PAYLOAD_W(PW), .LAT(LAT), .MAX_OUTST(MAXO)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus),
        .o_outst0     (outst0),
        .o_outst1     (outst1),
        .o_err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    // FMA model: issue-valid reappears LAT cycles later; reset flushes it.
    always @(posedge clk) begin
        if (rst) fma_pipe <= '0;
        else     fma_pipe <= {fma_pipe[LAT-2:0], bus.o_fma_valid};
    end
    assign bus.i_fma_valid = fma_pipe[LAT-1] | inject;

    function automatic logic [PW-1:0] pat(input int k, input int i);
        logic [PW-1:0] p;
        p = '0;
        p[PW-1 -: 8]  = 8'(8'hA0 + k);
        p[100 +: 32]  = 32'hDEAD0000 | 32'(i);
        p[15:0]       = 16'(i * 37 + k * 5 + 1);
        return p;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input int i);
        bus.i_req_valid = v;
        bus.i_req_data0 = pat(0, i);
        bus.i_req_data1 = pat(1, i);
    endtask

    task automatic expect_issue(input int id, input int i, input bit with_rsp);
        exp_iss_id.push_back(id);
        exp_iss_data.push_back(pat(id, i));
        if (with_rsp) exp_rsp_id.push_back(id);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        drive(2'b00, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic drain_and_check(input string tag);
        drive(2'b00, 0);
        repeat (LAT + 1) begin
            @(negedge clk);
            tick();
        end
        check({tag, "_iss_q_left"}, exp_iss_id.size(), 0);
        check({tag, "_rsp_q_left"}, exp_rsp_id.size(), 0);
        check({tag, "_outst0_end"}, outst0, 0);
        check({tag, "_outst1_end"}, outst1, 0);
        exp_iss_id.delete();
        exp_iss_data.delete();
        exp_rsp_id.delete();
    endtask

    // Monitor: pops expectations whenever the DUT issues or routes a response.
    always @(negedge clk) begin : mon
        int            id;
        logic [PW-1:0] d;
        if (bus.o_fma_valid || bus.o_req_ready != 2'b00) begin
            if (exp_iss_id.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL issue_unexpected: ready=%b valid=%b expected no issue",
                         bus.o_req_ready, bus.o_fma_valid);
            end else begin
                id = exp_iss_id.pop_front();
                d  = exp_iss_data.pop_front();
                check("issue_ready", bus.o_req_ready, (id == 1) ? 2 : 1);
                check("issue_valid", bus.o_fma_valid, 1);
                n_cmp++;
                if (bus.o_fma_data !== d) begin
                    n_err++;
                    $display("FAIL issue_data: got %h expected %h", bus.o_fma_data, d);
                end
            end
        end else begin
            n_cmp++;
            if (bus.o_fma_data !== '0) begin
                n_err++;
                $display("FAIL idle_data: got %h expected 0", bus.o_fma_data);
            end
        end
        if (bus.o_rsp_valid != 2'b00) begin
            if (exp_rsp_id.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got %b expected 00", bus.o_rsp_valid);
            end else begin
                id = exp_rsp_id.pop_front();
                check("rsp_valid", bus.o_rsp_valid, (id == 1) ? 2 : 1);
            end
        end
    end

    initial begin
        drive(2'b00, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        @(negedge clk);
        check("rst_outst0", outst0, 0);
        check("rst_outst1", outst1, 0);
        check("rst_orphan", err_orphan, 0);
        check("rst_ready", bus.o_req_ready, 0);
        check("rst_rsp", bus.o_rsp_valid, 0);
        tick();

        // Single issue from requester 0 and its credit lifetime.
        drive(2'b01, 0);
        expect_issue(0, 0, 1);
        @(negedge clk);
        check("a_fma_valid", bus.o_fma_valid, 1);
        tick();
        drive(2'b00, 0);
        @(negedge clk);
        check("a_outst0_t1", outst0, 1);
        tick();
        @(negedge clk);
        check("a_outst0_t2", outst0, 1);
        check("a_rsp_t2", bus.o_rsp_valid, 1);
        tick();
        @(negedge clk);
        check("a_outst0_t3", outst0, 0);
        drain_and_check("a");

        // Both requesters contend for six cycles.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, i);
            expect_issue(seq_b[i], i, 1);
            @(negedge clk);
            tick();
        end
        drain_and_check("b");

        // Requester 1 alone: credit limit throttles it to 2 of every 3 cycles.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(2'b10, i);
            if (rdy_c[i] == 1) expect_issue(1, i, 1);
            @(negedge clk);
            check("c_ready", bus.o_req_ready, (rdy_c[i] == 1) ? 2 : 0);
            check("c_outst1", outst1, out_c[i]);
            tick();
        end
        drain_and_check("c");

        // Spurious FMA valid with nothing in flight.
        inject = 1'b1;
        @(negedge clk);
        check("d_rsp_none", bus.o_rsp_valid, 0);
        check("d_orphan_pre", err_orphan, 0);
        tick();
        inject = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("d_orphan_sticky", err_orphan, 1);
            tick();
        end
        do_reset();
        @(negedge clk);
        check("d_orphan_cleared", err_orphan, 0);
        tick();

        // Reset with two operations in flight; last grant to 0 leaves rr at 1.
        drive(2'b10, 0);
        expect_issue(1, 0, 0);
        @(negedge clk);
        tick();
        drive(2'b01, 1);
        expect_issue(0, 1, 0);
        @(negedge clk);
        tick();
        rst = 1'b1;
        drive(2'b11, 2);
        @(negedge clk);
        check("e_ready_in_rst", bus.o_req_ready, 0);
        check("e_valid_in_rst", bus.o_fma_valid, 0);
        check("e_rsp_in_rst", bus.o_rsp_valid, 0);
        tick();
        rst = 1'b0;
        drive(2'b11, 3);
        expect_issue(0, 3, 1);
        @(negedge clk);
        check("e_outst0_after", outst0, 0);
        check("e_outst1_after", outst1, 0);
        check("e_orphan_after", err_orphan, 0);
        tick();
        drain_and_check("e");
        check("e_orphan_end", err_orphan, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
